// File: rtl/tcdm_bank_responder.sv
// TCDM SRAM bank responder: req/gnt in, fixed-latency vld/idx/rdata out.
// Optional LFSR grant stalls via `define TCDM_BANK_STALL_EN.
module tcdm_bank_responder #(
  parameter int          NumIn        = 32,
  parameter int          DataWidth    = 32,
  parameter int          BeWidth      = DataWidth / 8,
  parameter int          AddrMemWidth = 12,
  parameter int          Latency      = 1,
  parameter bit          WriteRespOn  = 1'b1,
  parameter logic [15:0] StallSeed    = 16'hACE1,
  localparam int         IdxWidth     = $clog2(NumIn)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [IdxWidth-1:0]     idx_i,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic                    vld_o,
  output logic [IdxWidth-1:0]     idx_o,
  output logic [DataWidth-1:0]    rdata_o
);

  if (Latency < 1) begin : g_bad_lat
    $fatal(1, "Latency must be >= 1");
  end

  logic [DataWidth-1:0] r_mem [2**AddrMemWidth];

  logic [Latency-1:0]   r_vld;
  logic [IdxWidth-1:0]  r_idx  [Latency];
  logic [DataWidth-1:0] r_data [Latency];

  logic w_txn;
  logic w_resp;
  logic w_rd;

`ifdef TCDM_BANK_STALL_EN
  if (StallSeed == 16'h0) begin : g_bad_seed
    $fatal(1, "StallSeed must be non-zero");
  end

  logic [15:0] r_lfsr;
  logic        w_fb;
  logic        w_stall;

  // taps 16,14,13,11 in 1-based numbering
  assign w_fb    = r_lfsr[15] ^ r_lfsr[13]
                 ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_stall = (r_lfsr[1:0] == 2'b00);
  assign gnt_o   = req_i & ~w_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= StallSeed;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end
`else
  if (StallSeed == 16'h0) begin : g_seed_ignored
  end

  assign gnt_o = req_i;
`endif

  assign w_txn  = req_i & gnt_o;
  assign w_rd   = w_txn & ~wen_i;
  assign w_resp = w_txn & (~wen_i | WriteRespOn);

  always_ff @(posedge clk_i) begin
    if (w_txn && wen_i) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (be_i[b]) begin
          r_mem[add_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // empty slots carry zero idx/data so the idle output is 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
      for (int i = 0; i < Latency; i++) begin
        r_idx[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= w_resp;
      r_idx[0]  <= w_resp ? idx_i : '0;
      r_data[0] <= w_rd ? r_mem[add_i] : '0;
      for (int i = 1; i < Latency; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_idx[i]  <= r_idx[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign vld_o   = r_vld[Latency-1];
  assign idx_o   = r_idx[Latency-1];
  assign rdata_o = r_data[Latency-1];

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: three configs share one stimulus
// stream and are checked against a queue/array transaction model.
module tb_tcdm_bank_responder;

  localparam int NK = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  int LAT [NK] = '{1, 3, 4};
  bit WRO [NK] = '{1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic [4:0]  idx = '0;
  logic [11:0] add = '0;
  logic [31:0] wd  = '0;
  logic [3:0]  be  = '0;

  logic [NK-1:0] gnt;
  logic [NK-1:0] vld;
  logic [4:0]    idxo [NK];
  logic [31:0]   rdo  [NK];

  always #5 clk = ~clk;

  tcdm_bank_responder #(.Latency(1), .WriteRespOn(1'b1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[0]),
    .idx_i(idx), .add_i(add), .wen_i(wen), .wdata_i(wd),
    .be_i(be), .vld_o(vld[0]), .idx_o(idxo[0]),
    .rdata_o(rdo[0]));

  tcdm_bank_responder #(.Latency(3), .WriteRespOn(1'b0)) u_l3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[1]),
    .idx_i(idx), .add_i(add), .wen_i(wen), .wdata_i(wd),
    .be_i(be), .vld_o(vld[1]), .idx_o(idxo[1]),
    .rdata_o(rdo[1]));

  tcdm_bank_responder #(.Latency(4), .WriteRespOn(1'b1)) u_l4 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[2]),
    .idx_i(idx), .add_i(add), .wen_i(wen), .wdata_i(wd),
    .be_i(be), .vld_o(vld[2]), .idx_o(idxo[2]),
    .rdata_o(rdo[2]));

  typedef struct {
    int          due;
    logic [4:0]  idx;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q [NK][$];
  logic [31:0] mem [int];
  int          edge_n = 0;
  logic [15:0] lfsr_m = SEED;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic step(input bit r, input bit rq, input bit w,
                      input logic [4:0] id, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      output bit g);
    rsp_t        e;
    logic [31:0] nm;
    rst = r; req = rq; wen = w; idx = id;
    add = a; wd = d; be = b;
    #1;
    g = rq;
`ifdef TCDM_BANK_STALL_EN
    g = rq && (lfsr_m[1:0] != 2'b00);
`endif
    for (int k = 0; k < NK; k++)
      chk($sformatf("k%0d_gnt", k), {31'b0, gnt[k]}, {31'b0, g});
    if (!r && g) begin
      for (int k = 0; k < NK; k++) begin
        if (!w || WRO[k]) begin
          e.due  = edge_n + LAT[k];
          e.idx  = id;
          e.data = w ? 32'h0 : mem[int'(a)];
          q[k].push_back(e);
        end
      end
      if (w) begin
        nm = mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (b[i]) nm[8*i +: 8] = d[8*i +: 8];
        mem[int'(a)] = nm;
      end
    end
    @(posedge clk);
    edge_n++;
    if (r) begin
      lfsr_m = SEED;
      for (int k = 0; k < NK; k++) q[k].delete();
    end else begin
      lfsr_m = {lfsr_m[14:0],
                lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
    @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      if (q[k].size() > 0 && q[k][0].due == edge_n) begin
        e = q[k].pop_front();
        chk($sformatf("k%0d_vld", k), {31'b0, vld[k]}, 32'd1);
        chk($sformatf("k%0d_idx", k), {27'b0, idxo[k]}, {27'b0, e.idx});
        chk($sformatf("k%0d_rdata", k), rdo[k], e.data);
      end else begin
        chk($sformatf("k%0d_vld0", k), {31'b0, vld[k]}, 32'd0);
        chk($sformatf("k%0d_idx0", k), {27'b0, idxo[k]}, 32'd0);
        chk($sformatf("k%0d_rdata0", k), rdo[k], 32'd0);
      end
    end
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, '0, g);
  endtask

  // retries until the model predicts a grant; bounded
  task automatic xfer(input bit w, input logic [4:0] id,
                      input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] b);
    bit g;
    int n;
    g = 1'b0;
    n = 0;
    while (!g && n < 32) begin
      step(0, 1, w, id, a, d, b, g);
      n++;
    end
    if (!g) chk("xfer_grant", 32'd0, 32'd1);
  endtask

  initial begin
    bit g;
    int nstall;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, '0, '0, g);
    idle(1);
    for (int i = 0; i < 16; i++)
      xfer(1, 5'(i), 12'(i), 32'h01010101 * i, 4'hF);
    idle(5);

    xfer(1, 5'd3, 12'd5, 32'hDEADBEEF, 4'hF);
    chk("wr_rsp_vld", {31'b0, vld[0]}, 32'd1);
    chk("wr_rsp_idx", {27'b0, idxo[0]}, 32'd3);
    chk("wr_rsp_data", rdo[0], 32'd0);
    xfer(0, 5'd7, 12'd5, '0, '0);
    chk("rd_rsp_idx", {27'b0, idxo[0]}, 32'd7);
    chk("rd_rsp_data", rdo[0], 32'hDEADBEEF);

    xfer(1, 5'd1, 12'd9, 32'h11223344, 4'hF);
    xfer(1, 5'd1, 12'd9, 32'hAABBCCDD, 4'b0101);
    xfer(0, 5'd2, 12'd9, '0, '0);
    chk("partial_wr", rdo[0], 32'h11BB33DD);
    idle(5);

    for (int i = 0; i < 8; i++) xfer(0, 5'(i), 12'(i), '0, '0);
    idle(5);

    for (int i = 0; i < 4; i++) begin
      xfer(1, 5'(i), 12'd2, $urandom, 4'hF);
      xfer(0, 5'(i + 8), 12'd2, '0, '0);
    end
    idle(5);

    for (int i = 0; i < 3; i++) xfer(0, 5'(i), 12'(i), '0, '0);
    step(1, 0, 0, '0, '0, '0, '0, g);
    idle(8);
    xfer(0, 5'd9, 12'd5, '0, '0);
    chk("post_rst_rd", rdo[0], mem[5]);
    idle(5);

    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           5'($urandom), 12'($urandom_range(0, 15)), $urandom,
           4'($urandom), g);
    idle(5);

    nstall = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0, 1, $urandom_range(0, 1) == 1, 5'($urandom),
           12'($urandom_range(0, 15)), $urandom, 4'($urandom), g);
      if (!g) nstall++;
    end
`ifdef TCDM_BANK_STALL_EN
    chk("stall_rate", {31'b0, (nstall >= 200 && nstall <= 300)}, 32'd1);
`else
    chk("no_stall", nstall, 32'd0);
`endif
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
